// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int PORT_CPU      = 0;
  localparam int PORT_DMA      = 1;
  localparam int DEF_MEM_DEPTH = 4096;

  function automatic logic [1:0] port_oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant select: locked owner wins outright, otherwise round-robin on contention.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  input  arb_state_e state,
  output logic [1:0] gnt,
  output logic       sel
);

  always_comb begin
    sel = 1'(PORT_CPU);
    gnt = 2'b00;
    case (state)
      LOCK0: begin
        sel = 1'(PORT_CPU);
        gnt = {1'b0, req[0]};
      end
      LOCK1: begin
        sel = 1'(PORT_DMA);
        gnt = {req[1], 1'b0};
      end
      default: begin
        sel = (&req) ? rr : req[1];
        gnt = (|req) ? port_oh(sel) : 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shared single-port data RAM arbiter between CPU (port 0) and loader/DMA (port 1),
// with locked bursts, registered read return and out-of-range flagging.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            lock,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rvalid,
  output logic [1:0]            err,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam bit               ONE_SHOT = (MAX_BURST <= 1);

  logic [1:0][ADDR_W-1:0] a;
  logic [1:0][DATA_W-1:0] d;
  assign a = addr;
  assign d = wdata;

  arb_state_e        state;
  logic              rr;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        pick_gnt;
  logic              sel, oth, txn, in_rng;

  ram_arb_pick u_pick (
    .req   (req),
    .rr    (rr),
    .state (state),
    .gnt   (pick_gnt),
    .sel   (sel)
  );

  // Grant is gated by reset so an in-flight write cannot reach the falling edge.
  assign gnt     = rst_n ? pick_gnt : 2'b00;
  assign txn     = |gnt;
  assign oth     = ~sel;
  assign in_rng  = {1'b0, a[sel]} < DEPTH_C;
  assign cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  assign mem_we    = txn & we[sel] & in_rng;
  assign mem_addr  = txn ? a[sel] : '0;
  assign mem_wdata = txn ? d[sel] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr     <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
      rvalid <= 2'b00;
      err    <= 2'b00;
    end else begin
      rvalid <= 2'b00;
      err    <= 2'b00;
      if (txn) begin
        rr <= oth;
        if (!we[sel]) begin
          rvalid <= port_oh(sel);
          rdata  <= in_rng ? mem_rdata : '0;
        end
        if (!in_rng) err <= port_oh(sel);
      end
      case (state)
        IDLE: begin
          if (txn && lock[sel] && !(ONE_SHOT && req[oth])) begin
            state <= sel ? LOCK1 : LOCK0;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          // sel is the owner here; count saturates when nobody else is waiting.
          if (!req[sel] || !lock[sel] || (cnt_nxt == CNT_MAX && req[oth])) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed cycles push expected read/err responses,
// a negedge monitor pops and checks them against the registered outputs.
module tb_ram_arbiter;

  logic        clk, rst_n;
  logic [1:0]  req, lock, we, gnt, rvalid, err;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] mem_addr;

  logic [7:0]  mem [0:4095];
  int          total = 0, bad = 0, cyc_n = 0;

  typedef struct {
    logic [1:0] rv;
    logic [1:0] er;
    logic [7:0] rd;
    logic       cd;
    int         due;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .err(err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:0]];
  always @(negedge clk) if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic expect_out(input logic p, input logic rd_op, input logic oor, input logic [7:0] d);
    exp_t x;
    x.rv  = rd_op ? (p ? 2'b10 : 2'b01) : 2'b00;
    x.er  = oor   ? (p ? 2'b10 : 2'b01) : 2'b00;
    x.rd  = d;
    x.cd  = rd_op;
    x.due = cyc_n + 1;
    sbq.push_back(x);
  endtask

  // Called at posedge+1; applies inputs, checks the combinational side at negedge.
  task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] eg, input logic emwe);
    req = r; lock = l; we = w; addr = {a1, a0}; wdata = {d1, d0};
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("mem_we", 32'(mem_we), 32'(emwe));
    chk("mem_addr", 32'(mem_addr), 32'(eg == 2'b01 ? a0 : eg == 2'b10 ? a1 : 16'h0));
    chk("mem_wdata", 32'(mem_wdata), 32'(eg == 2'b01 ? d0 : eg == 2'b10 ? d1 : 8'h0));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; lock = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per cycle with rvalid or err raised.
  always @(negedge clk) begin
    if (rvalid != 2'b00 || err != 2'b00) begin
      if (sbq.size() == 0) chk("unexpected_out", 32'({rvalid, err}), 32'h0);
      else begin
        e = sbq.pop_front();
        chk("rvalid", 32'(rvalid), 32'(e.rv));
        chk("err", 32'(err), 32'(e.er));
        if (e.cd) chk("rdata", 32'(rdata), 32'(e.rd));
        chk("latency", 32'(cyc_n), 32'(e.due));
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc_n) begin
      e = sbq.pop_front();
      chk("missing_out", 32'(cyc_n), 32'(e.due - 1));
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;

    // Reset: grant forced low even with both ports requesting writes.
    rst_n = 1'b0; req = 2'b11; lock = 2'b00; we = 2'b11;
    addr = {16'h0101, 16'h0101}; wdata = 16'h2A2A;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b00; we = 2'b00;

    // Port 0 write 0x2A to 0x0101 then read it back.
    cyc(2'b01, 2'b00, 2'b01, 16'h0101, 16'h0, 8'h2A, 8'h0, 2'b01, 1'b1);
    expect_out(1'b0, 1'b1, 1'b0, 8'h2A);
    cyc(2'b01, 2'b00, 2'b00, 16'h0101, 16'h0, 8'h00, 8'h0, 2'b01, 1'b0);
    idle();
    chk("mem_0101", 32'(mem[12'h101]), 32'h2A);

    // Contention from reset: 0,1,0,1.
    do_reset();
    expect_out(1'b0, 1'b1, 1'b0, 8'hA5);
    cyc(2'b11, 2'b00, 2'b00, 16'h0200, 16'h0301, 8'h0, 8'h0, 2'b01, 1'b0);
    expect_out(1'b1, 1'b1, 1'b0, 8'hA4);
    cyc(2'b11, 2'b00, 2'b00, 16'h0200, 16'h0301, 8'h0, 8'h0, 2'b10, 1'b0);
    expect_out(1'b0, 1'b1, 1'b0, 8'hA5);
    cyc(2'b11, 2'b00, 2'b00, 16'h0200, 16'h0301, 8'h0, 8'h0, 2'b01, 1'b0);
    expect_out(1'b1, 1'b1, 1'b0, 8'hA4);
    cyc(2'b11, 2'b00, 2'b00, 16'h0200, 16'h0301, 8'h0, 8'h0, 2'b10, 1'b0);
    idle();

    // Port 1 locked burst: 4 grants despite port 0 waiting, then port 0.
    expect_out(1'b1, 1'b1, 1'b0, 8'hA7);
    cyc(2'b10, 2'b10, 2'b00, 16'h0200, 16'h0302, 8'h0, 8'h0, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      expect_out(1'b1, 1'b1, 1'b0, 8'hA7);
      cyc(2'b11, 2'b10, 2'b00, 16'h0200, 16'h0302, 8'h0, 8'h0, 2'b10, 1'b0);
    end
    expect_out(1'b0, 1'b1, 1'b0, 8'hA5);
    cyc(2'b11, 2'b10, 2'b00, 16'h0200, 16'h0302, 8'h0, 8'h0, 2'b01, 1'b0);
    expect_out(1'b1, 1'b1, 1'b0, 8'hA7);
    cyc(2'b10, 2'b00, 2'b00, 16'h0200, 16'h0302, 8'h0, 8'h0, 2'b10, 1'b0);
    expect_out(1'b0, 1'b1, 1'b0, 8'hA5);
    cyc(2'b11, 2'b00, 2'b00, 16'h0200, 16'h0302, 8'h0, 8'h0, 2'b01, 1'b0);
    idle();

    // Out of range write / read, plus last in-range byte.
    expect_out(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(2'b01, 2'b00, 2'b01, 16'h1000, 16'h0, 8'h55, 8'h0, 2'b01, 1'b0);
    expect_out(1'b0, 1'b1, 1'b1, 8'h00);
    cyc(2'b01, 2'b00, 2'b00, 16'h1000, 16'h0, 8'h00, 8'h0, 2'b01, 1'b0);
    expect_out(1'b0, 1'b1, 1'b0, 8'h5A);
    cyc(2'b01, 2'b00, 2'b00, 16'h0FFF, 16'h0, 8'h00, 8'h0, 2'b01, 1'b0);
    idle();
    chk("mem_0000", 32'(mem[12'h000]), 32'hA5);

    // Reset mid-burst during a port 1 write.
    cyc(2'b10, 2'b10, 2'b10, 16'h0, 16'h0400, 8'h0, 8'h77, 2'b10, 1'b1);
    chk("mem_0400", 32'(mem[12'h400]), 32'h77);
    rst_n = 1'b0;
    cyc(2'b10, 2'b10, 2'b10, 16'h0, 16'h0401, 8'h0, 8'h99, 2'b00, 1'b0);
    chk("mem_0401", 32'(mem[12'h401]), 32'hA4);
    rst_n = 1'b1;
    expect_out(1'b0, 1'b1, 1'b0, 8'hA5);
    cyc(2'b11, 2'b00, 2'b00, 16'h0200, 16'h0301, 8'h0, 8'h0, 2'b01, 1'b0);
    expect_out(1'b1, 1'b1, 1'b0, 8'hA4);
    cyc(2'b10, 2'b00, 2'b00, 16'h0200, 16'h0301, 8'h0, 8'h0, 2'b10, 1'b0);
    repeat (3) idle();

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
